shake_pad_stream: RTL and testbench
===================================

// Module: shake_pad_stream
// PURPOSE
//  Streaming successor to the combinational SHAKE pad stage. Accepts a message of
//  arbitrary bit length as W-bit words over a valid/ready stream and packs it into
//  RATE-bit blocks. Appends the domain-separation suffix and pad10*1, spilling into
//  an extra block when needed. Emits blocks to the Keccak absorb stage over a second
//  valid/ready stream.
// PARAMETERS
//  RATE     1088     block size in bits; must be a multiple of W
//  W        64       input word width in bits
//  DS_BITS  4        domain-separation suffix length in bits, 1..8
//  DS_VAL   4'b1111  suffix value; DS_VAL[0] is placed first (lowest bit index)
// PORTS
//  clk        in   1               clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               input word valid
//  in_ready   out  1               input word accepted when in_valid & in_ready
//  in_data    in   W               message bits, LSB first; bit 0 = earliest bit
//  in_bits    in   clog2(W+1)      valid bits in in_data (LSB-aligned); used only when in_last
//  in_last    in   1               final word of the message
//  blk_valid  out  1               output block valid
//  blk_ready  in   1               output block accepted when blk_valid & blk_ready
//  blk_data   out  RATE            block; bit i = absolute message bit (k*RATE + i)
//  blk_last   out  1               block is the final block of the message
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=ABSORB, ptr=0, buffer=0, blk_valid=0,
//    blk_last=0, blk_data=0. in_ready=0 while rst_n=0. Reset mid-message discards all
//    partial data; nothing is emitted.
//  - States: ABSORB, EMIT, EMIT_PAD. in_ready=1 only in ABSORB. blk_valid=1 only in
//    EMIT and EMIT_PAD.
//  - ABSORB: on handshake, write nb bits at buffer[ptr +: nb].
//      - nb=W when !in_last; nb=min(in_bits,W) when in_last.
//      - Unused in_data bits are masked to 0.
//      - ptr += nb.
//  - Non-last word with ptr+W==RATE: go to EMIT with blk_last=0. Block appears on
//    blk_data the cycle after the handshake; ptr clears to 0 on the EMIT handshake.
//  - Last word: let p = (ptr+nb) mod RATE. A last word that exactly fills the block
//    emits it with blk_last=0, then a pad-only block with p=0.
//      - Tail bits are DS_VAL (DS_BITS bits), then a single '1', at absolute positions
//        p .. p+DS_BITS.
//      - L = p+DS_BITS+1.
//      - If L+1 <= RATE: one final block; bit RATE-1 is also set; blk_last=1.
//      - Else: the current block holds tail bits below RATE (blk_last=0). Next state
//        is EMIT_PAD. The pad block holds tail bits at index (pos-RATE) plus bit
//        RATE-1 set; blk_last=1.
//      - Covers a suffix split across blocks, and the '1' landing exactly on RATE-1.
//  - blk_data and blk_last are stable while blk_valid & !blk_ready (no change under
//    backpressure).
//  - On the blk_last handshake: buffer and ptr clear, return to ABSORB. in_ready=1 on
//    the next cycle, so back-to-back messages are allowed.
//  - Throughput: one word per cycle in ABSORB. One bubble per block.
//  - A message of a single word with in_last=1, in_bits=0 is the empty message.
//    in_bits>W is clamped to W.
//  - All ptr arithmetic is clog2(RATE+1) bits wide; no wrap beyond RATE.
// TESTING (RATE=1088, W=64, DS=1111 unless noted)
//  1. Empty msg (one word, last, in_bits=0) -> one block: bits[4:0]=5'b11111,
//     bit1087=1, rest 0, blk_last=1.
//  2. 1000-bit msg (15 full words + 40 bits last) -> one block: msg in [999:0],
//     [1004:1000]=11111, bit1087=1, blk_last=1.
//  3. Boundary p=1082 -> single block: [1086:1082]=1s, bit1087=1.
//     p=1083 -> block 1: [1087:1083]=1s; block 2: only bit1087=1.
//     p=1086 -> block 1: [1087:1086]=1s; block 2: [2:0]=1s, bit1087=1.
//  4. Exact fill (17 full words, last on 17th) -> block 1: message, blk_last=0;
//     block 2: [4:0]=1s, bit1087=1, blk_last=1.
//  5. blk_ready low 6 cycles during EMIT -> blk_valid=1, blk_data unchanged,
//     in_ready=0. Then two messages back-to-back: blocks in order, correct blk_last.
//  6. rst_n pulsed low after 10 words -> blk_valid=0 immediately. Next message
//     output is independent of the discarded data.

Source files
------------

// File: rtl/shake_pad_stream.sv
// Streaming SHAKE pad stage: packs W-bit message words into RATE-bit blocks and appends
// the domain-separation suffix plus pad10*1, spilling into an extra block when needed.
module shake_pad_stream #(
    parameter int unsigned RATE    = 1088,
    parameter int unsigned W       = 64,
    parameter int unsigned DS_BITS = 4,
    parameter logic [7:0]  DS_VAL  = 8'b0000_1111,
    localparam int unsigned PW     = $clog2(RATE + 1),
    localparam int unsigned BW     = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [BW-1:0]   in_bits,
    input  logic            in_last,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [RATE-1:0] blk_data,
    output logic            blk_last
);

    // Largest end-of-message position whose suffix, '1' and final pad bit all fit.
    localparam int unsigned SPLIT_AT = RATE - DS_BITS - 2;
    localparam logic [2*RATE-1:0] TAIL_PAT =
        {{(2*RATE-DS_BITS-1){1'b0}}, 1'b1, DS_VAL[DS_BITS-1:0]};
    localparam logic [RATE-1:0] TOP_BIT = {1'b1, {(RATE-1){1'b0}}};

    typedef enum logic [1:0] {StAbsorb, StEmit, StEmitPad} state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [RATE-1:0]   buf_q;
    logic [RATE-1:0]   pad_q;
    logic              pad_pend_q;
    logic              in_ready_q;
    logic              blk_valid_q;
    logic              blk_last_q;

    logic [BW-1:0]     nb;
    logic [W-1:0]      word_mask;
    logic [RATE-1:0]   word_ext;
    logic [RATE-1:0]   merged;
    logic [PW-1:0]     p;
    logic [2*RATE-1:0] tail;
    logic              fits;

    always_comb begin
        nb        = BW'(W);
        if (in_last) begin
            nb = (in_bits > BW'(W)) ? BW'(W) : in_bits;
        end
        word_mask = ~({W{1'b1}} << nb);
        word_ext  = {{(RATE-W){1'b0}}, in_data & word_mask};
        merged    = buf_q | (word_ext << ptr_q);
        p         = ptr_q + PW'(nb);
        // p may equal RATE (exact fill); the tail then lands wholly in the upper half.
        tail      = TAIL_PAT << p;
        fits      = (p <= PW'(SPLIT_AT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAbsorb;
            ptr_q       <= '0;
            buf_q       <= '0;
            pad_q       <= '0;
            pad_pend_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StAbsorb: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        if (in_last) begin
                            state_q     <= StEmit;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            ptr_q       <= p;
                            if (fits) begin
                                buf_q      <= merged | tail[RATE-1:0] | TOP_BIT;
                                blk_last_q <= 1'b1;
                                pad_pend_q <= 1'b0;
                            end else begin
                                buf_q      <= merged | tail[RATE-1:0];
                                pad_q      <= tail[2*RATE-1:RATE] | TOP_BIT;
                                blk_last_q <= 1'b0;
                                pad_pend_q <= 1'b1;
                            end
                        end else begin
                            buf_q <= merged;
                            ptr_q <= p;
                            if (p == PW'(RATE)) begin
                                state_q     <= StEmit;
                                in_ready_q  <= 1'b0;
                                blk_valid_q <= 1'b1;
                                blk_last_q  <= 1'b0;
                                pad_pend_q  <= 1'b0;
                            end
                        end
                    end
                end
                StEmit: begin
                    if (blk_ready) begin
                        ptr_q <= '0;
                        if (pad_pend_q) begin
                            state_q    <= StEmitPad;
                            buf_q      <= pad_q;
                            pad_q      <= '0;
                            pad_pend_q <= 1'b0;
                            blk_last_q <= 1'b1;
                        end else begin
                            state_q     <= StAbsorb;
                            buf_q       <= '0;
                            blk_valid_q <= 1'b0;
                            blk_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                StEmitPad: begin
                    if (blk_ready) begin
                        state_q     <= StAbsorb;
                        ptr_q       <= '0;
                        buf_q       <= '0;
                        blk_valid_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StAbsorb;
                    ptr_q       <= '0;
                    buf_q       <= '0;
                    blk_valid_q <= 1'b0;
                    blk_last_q  <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = buf_q;
    assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_shake_pad_stream.sv
// Scoreboard bench for shake_pad_stream: random messages, reference padding built from
// a flat bit queue, output blocks checked by an independent monitor.
module tb_shake_pad_stream;

    localparam int unsigned RATE    = 1088;
    localparam int unsigned W       = 64;
    localparam int unsigned DS_BITS = 4;
    localparam logic [7:0]  DS_VAL  = 8'b0000_1111;
    localparam int unsigned BW      = $clog2(W + 1);

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [BW-1:0]   in_bits;
    logic            in_last;
    logic            blk_valid;
    logic            blk_ready;
    logic [RATE-1:0] blk_data;
    logic            blk_last;

    shake_pad_stream #(
        .RATE    (RATE),
        .W       (W),
        .DS_BITS (DS_BITS),
        .DS_VAL  (DS_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bits   (in_bits),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [RATE-1:0] data;
        logic            last;
    } blk_t;

    blk_t exp_q[$];
    bit   cur_msg[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int   blk_idx  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: message ++ suffix ++ pad10*1 up to a whole number of blocks.
    task automatic build_expected();
        bit          pq[$];
        logic [7:0]  ds;
        blk_t        b;
        int          nblk;
        ds = DS_VAL;
        pq = cur_msg;
        for (int j = 0; j < int'(DS_BITS); j++) pq.push_back(ds[j]);
        pq.push_back(1'b1);
        while ((pq.size() + 1) % RATE != 0) pq.push_back(1'b0);
        pq.push_back(1'b1);
        nblk = pq.size() / RATE;
        for (int k = 0; k < nblk; k++) begin
            for (int i = 0; i < int'(RATE); i++) b.data[i] = pq[k*RATE + i];
            b.last = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_word(input logic [W-1:0] d, input logic [BW-1:0] nb, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_bits  = nb;
        in_last  = last;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL in_handshake_timeout: got in_ready=0 for 3000 cycles, required 1");
        end
    endtask

    task automatic send_msg(input int nbits, input bit do_last);
        int            nw;
        int            rem;
        int            nb;
        logic [W-1:0]  d;
        logic [BW-1:0] bf;
        cur_msg.delete();
        for (int i = 0; i < nbits; i++) cur_msg.push_back(bit'($urandom_range(0, 1)));
        if (do_last) build_expected();
        nw = (nbits == 0) ? 1 : (nbits + W - 1) / W;
        for (int w = 0; w < nw; w++) begin
            d   = {$urandom, $urandom};   // bits beyond the message are garbage
            rem = nbits - w * W;
            nb  = (rem >= int'(W)) ? int'(W) : rem;
            for (int i = 0; i < nb; i++) d[i] = cur_msg[w*W + i];
            if (do_last && w == nw - 1) begin
                bf = BW'(nb);
                if (nb == int'(W) && $urandom_range(0, 1) == 1) bf = BW'(W + $urandom_range(0, 63));
                if ($urandom_range(0, 4) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                drive_word(d, bf, 1'b1);
            end else begin
                drive_word(d, BW'($urandom_range(0, 127)), 1'b0);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 6000; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       blk_ready = ($urandom_range(0, 2) != 0);
                2:       blk_ready = 1'b0;
                default: blk_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations on output handshakes, checks hold under backpressure.
    initial begin
        logic [RATE-1:0] prev_data;
        logic            prev_last;
        bit              prev_pend;
        blk_t            e;
        prev_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    n_vec++;
                    if (!(blk_valid && blk_data == prev_data && blk_last == prev_last)) begin
                        n_err++;
                        $display("FAIL hold_stable: got valid=%0b last=%0b data[63:0]=%h, required valid=1 last=%0b data[63:0]=%h",
                                 blk_valid, blk_last, blk_data[63:0], prev_last, prev_data[63:0]);
                    end
                end
                if (blk_valid) begin
                    n_vec++;
                    if (in_ready) begin
                        n_err++;
                        $display("FAIL in_ready_while_emit: got 1 required 0");
                    end
                end
                if (blk_valid && blk_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_block #%0d: got block with last=%0b, required none",
                                 blk_idx, blk_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (blk_data !== e.data || blk_last !== e.last) begin
                            n_err++;
                            $display("FAIL block #%0d: got last=%0b hi=%h lo=%h, required last=%0b hi=%h lo=%h",
                                     blk_idx, blk_last, blk_data[RATE-1:RATE-64], blk_data[127:0],
                                     e.last, e.data[RATE-1:RATE-64], e.data[127:0]);
                        end
                    end
                    blk_idx++;
                end
                prev_pend = blk_valid && !blk_ready;
                prev_data = blk_data;
                prev_last = blk_last;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_bits  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_blk_valid", 32'(blk_valid), 32'd0);
        chk("reset_blk_last", 32'(blk_last), 32'd0);
        chk("reset_blk_data_zero", 32'(blk_data == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty, 1000-bit, boundary positions, exact fill, two full blocks
        rdy_mode = 0;
        send_msg(0, 1'b1);
        send_msg(1000, 1'b1);
        send_msg(1082, 1'b1);
        send_msg(1083, 1'b1);
        send_msg(1086, 1'b1);
        send_msg(1087, 1'b1);
        send_msg(1088, 1'b1);
        send_msg(2176, 1'b1);
        send_msg(2170, 1'b1);
        drain();

        // Backpressure held for 6 cycles, then back-to-back messages
        rdy_mode = 2;
        send_msg(100, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (blk_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_blk_valid_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        chk("bp_blk_valid_held", 32'(blk_valid), 32'd1);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_msg(300, 1'b1);
        send_msg(64, 1'b1);
        drain();

        rdy_mode = 1;
        for (int m = 0; m < 14; m++) send_msg(int'($urandom_range(0, 3000)), 1'b1);
        drain();

        // Reset mid-message discards partial data
        rdy_mode = 0;
        send_msg(640, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_blk_valid", 32'(blk_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(200, 1'b1);
        send_msg(1085, 1'b1);
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
